bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Shares the single external memory bus between two masters: M0 (CPU core) and M1 (debug/loader port).
- Each master uses the same req/done handshake as the CPU bus: level read/write request, one-cycle done pulse.
- Registered grant, round-robin on ties, per-transaction timeout so a dead downstream cannot hang the core.
- Sits between the cpu instance and the memory/IO controller at the top level.

Parameters:
TIMEOUT, 64, cycles in ACCESS before forced completion; 0 disables timeout; legal range 0..255.

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
m0_address  input  16  M0 address, held stable while request is high
m0_wdata  input  8  M0 write data
m0_read  input  1  M0 read request (level)
m0_write  input  1  M0 write request (level)
m0_rdata  output  8  read data to M0, held until the next M0 completion
m0_done  output  1  one-cycle completion pulse to M0
m1_address, m1_wdata, m1_read, m1_write, m1_rdata, m1_done  same as the M0 ports, for M1
mem_address  output  16  downstream address
mem_wdata  output  8  downstream write data
mem_read  output  1  downstream read strobe (level)
mem_write  output  1  downstream write strobe (level)
mem_rdata  input  8  downstream read data, valid when mem_done=1
mem_done  input  1  downstream completion
grant  output  1  owner of the current or last transaction (0=M0, 1=M1)
timeout_pulse  output  1  one-cycle pulse on a forced completion

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset values:
  - state=IDLE.
  - All mem_* outputs 0.
  - m0_rdata=m1_rdata=8'h00, m0_done=m1_done=0.
  - grant=1, so M0 wins the first tie.
  - timeout_pulse=0, counter=0.
- Reset mid-transaction drops mem_read/mem_write on that edge. No done pulse is issued.
- All outputs are registered.
- A request is active when read|write is high. If both read and write are high, write wins.
- IDLE:
  - One master requesting: select it.
  - Both requesting: select the master that is not equal to grant (round-robin).
  - On selection, at that edge:
    - Latch address and wdata into mem_address/mem_wdata.
    - Set mem_read or mem_write.
    - Set grant to the selected master; clear the counter; go to ACCESS.
  - No request: outputs hold.
- ACCESS:
  - mem_done=1: capture mem_rdata into the granted master's rdata (reads only; writes leave rdata unchanged). Clear mem strobes, pulse that master's done, go to RESPOND.
  - Else, if TIMEOUT!=0 and counter==TIMEOUT-1: clear strobes, set granted rdata=8'hFF for reads, pulse done and timeout_pulse, go to RESPOND.
  - Else: counter+1, saturating at 8 bits.
  - Master request inputs are ignored in ACCESS. The latched address/data are used.
- RESPOND:
  - done and timeout_pulse return to 0; go to IDLE.
  - Requests are ignored in this cycle; masters drop the request on the cycle after done.
- Latency:
  - Request seen at edge N: mem strobe high during cycle N+1.
  - mem_done at edge K: master done high during cycle K+1.
  - Next arbitration is at edge K+2.
  - Minimum master-visible latency is 3 cycles with mem_done returned immediately.
- The non-granted master's done stays 0 and its rdata is unchanged.
- mem_done outside ACCESS is ignored.

Test Plan:
- Reset, then M0 read 0x1234 with memory returning 0x5A after 2 cycles:
  - mem_read=1 and mem_address=0x1234 one cycle after the request.
  - m0_done is a single pulse with m0_rdata=0x5A, grant=0, m1_done stays 0.
- M0 write 0x00FF data 0x3C:
  - mem_write=1 and mem_wdata=0x3C; mem_read stays 0.
  - m0_done pulse; m0_rdata unchanged.
- Both masters request reads in the same cycle right after reset, each request held until its done:
  - M0 served first, then M1; grant sequence 0,1.
  - Repeated simultaneous requests alternate 0,1,0,1.
- Memory never asserts mem_done, TIMEOUT=4:
  - Strobe drops after 4 ACCESS cycles.
  - m0_done and timeout_pulse pulse together; m0_rdata=0xFF.
  - Next request is arbitrated normally.
- rst_n low while in ACCESS with mem_read=1:
  - mem_read=0 and all outputs at reset values on the next edge; no done pulse.
- M1 asserts read and write together at 0xBEEF:
  - Write is issued (mem_write=1, mem_read=0); m1_done pulse.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master arbiter for the shared external memory bus.
// M0 is the CPU core, M1 the debug/loader port. Both use the level
// read/write request with a one-cycle done pulse. Grant is registered,
// ties go round-robin, and a per-transaction timeout forces completion
// (read data 8'hFF) so a dead downstream device cannot hang the core.
module bus_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] m0_address,
  input  logic [7:0]  m0_wdata,
  input  logic        m0_read,
  input  logic        m0_write,
  output logic [7:0]  m0_rdata,
  output logic        m0_done,
  input  logic [15:0] m1_address,
  input  logic [7:0]  m1_wdata,
  input  logic        m1_read,
  input  logic        m1_write,
  output logic [7:0]  m1_rdata,
  output logic        m1_done,
  output logic [15:0] mem_address,
  output logic [7:0]  mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_done,
  output logic        grant,
  output logic        timeout_pulse
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

  localparam bit         TIMEOUT_EN = (TIMEOUT != 0);
  localparam logic [7:0] TO_LAST    = TIMEOUT_EN ? 8'(TIMEOUT - 1) : 8'd0;

  state_t      state, state_nx;
  logic [7:0]  counter, counter_nx;
  logic [15:0] mem_address_nx;
  logic [7:0]  mem_wdata_nx;
  logic        mem_read_nx, mem_write_nx;
  logic [7:0]  m0_rdata_nx, m1_rdata_nx;
  logic        m0_done_nx, m1_done_nx;
  logic        grant_nx, timeout_pulse_nx;
  logic        m0_req, m1_req, sel, sel_write;

  assign m0_req = m0_read | m0_write;
  assign m1_req = m1_read | m1_write;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nx         = state;
    counter_nx       = counter;
    mem_address_nx   = mem_address;
    mem_wdata_nx     = mem_wdata;
    mem_read_nx      = mem_read;
    mem_write_nx     = mem_write;
    m0_rdata_nx      = m0_rdata;
    m1_rdata_nx      = m1_rdata;
    m0_done_nx       = 1'b0;
    m1_done_nx       = 1'b0;
    grant_nx         = grant;
    timeout_pulse_nx = 1'b0;
    sel              = (m0_req && m1_req) ? ~grant : m1_req;
    sel_write        = sel ? m1_write : m0_write;

    unique case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          mem_address_nx = sel ? m1_address : m0_address;
          mem_wdata_nx   = sel ? m1_wdata : m0_wdata;
          mem_write_nx   = sel_write;
          mem_read_nx    = ~sel_write;
          grant_nx       = sel;
          counter_nx     = 8'd0;
          state_nx       = ACCESS;
        end
      end

      ACCESS: begin
        if (mem_done) begin
          mem_read_nx  = 1'b0;
          mem_write_nx = 1'b0;
          if (mem_read) begin
            if (grant) m1_rdata_nx = mem_rdata;
            else       m0_rdata_nx = mem_rdata;
          end
          m0_done_nx = ~grant;
          m1_done_nx = grant;
          state_nx   = RESPOND;
        end else if (TIMEOUT_EN && (counter == TO_LAST)) begin
          mem_read_nx  = 1'b0;
          mem_write_nx = 1'b0;
          if (mem_read) begin
            if (grant) m1_rdata_nx = 8'hFF;
            else       m0_rdata_nx = 8'hFF;
          end
          m0_done_nx       = ~grant;
          m1_done_nx       = grant;
          timeout_pulse_nx = 1'b1;
          state_nx         = RESPOND;
        end else if (counter != 8'hFF) begin
          counter_nx = counter + 8'd1;
        end
      end

      RESPOND: begin
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      counter       <= 8'd0;
      mem_address   <= 16'h0000;
      mem_wdata     <= 8'h00;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      m0_rdata      <= 8'h00;
      m1_rdata      <= 8'h00;
      m0_done       <= 1'b0;
      m1_done       <= 1'b0;
      grant         <= 1'b1;
      timeout_pulse <= 1'b0;
    end else begin
      state         <= state_nx;
      counter       <= counter_nx;
      mem_address   <= mem_address_nx;
      mem_wdata     <= mem_wdata_nx;
      mem_read      <= mem_read_nx;
      mem_write     <= mem_write_nx;
      m0_rdata      <= m0_rdata_nx;
      m1_rdata      <= m1_rdata_nx;
      m0_done       <= m0_done_nx;
      m1_done       <= m1_done_nx;
      grant         <= grant_nx;
      timeout_pulse <= timeout_pulse_nx;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (TIMEOUT = 4).
// Inputs change and outputs are sampled on the falling edge.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] m0_address, m1_address;
  logic [7:0]  m0_wdata, m1_wdata;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [7:0]  m0_rdata, m1_rdata;
  logic        m0_done, m1_done;
  logic [15:0] mem_address;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_read, mem_write, mem_done;
  logic        grant, timeout_pulse;

  int n_compared   = 0;
  int n_mismatched = 0;

  bus_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_address(m0_address), .m0_wdata(m0_wdata), .m0_read(m0_read),
    .m0_write(m0_write), .m0_rdata(m0_rdata), .m0_done(m0_done),
    .m1_address(m1_address), .m1_wdata(m1_wdata), .m1_read(m1_read),
    .m1_write(m1_write), .m1_rdata(m1_rdata), .m1_done(m1_done),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .grant(grant), .timeout_pulse(timeout_pulse)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Hold reset for two edges with all inputs idle; returns on a falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    m0_address = '0; m0_wdata = '0; m0_read = 1'b0; m0_write = 1'b0;
    m1_address = '0; m1_wdata = '0; m1_read = 1'b0; m1_write = 1'b0;
    mem_rdata = '0; mem_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Memory answers in the n-th ACCESS cycle; returns in the done cycle.
  task automatic serve(input int n, input logic [7:0] data);
    repeat (n - 1) @(negedge clk);
    mem_done  = 1'b1;
    mem_rdata = data;
    @(negedge clk);
    mem_done  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_compared++;
    if ({mem_read, mem_write, m0_done, m1_done, timeout_pulse} !== 5'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_strobes: got %b expected 00000",
               {mem_read, mem_write, m0_done, m1_done, timeout_pulse});
    end
    n_compared++;
    if (grant !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL reset_grant: got %b expected 1", grant);
    end
    n_compared++;
    if ({m0_rdata, m1_rdata, mem_address, mem_wdata} !== 40'h0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_data: got %h expected 0",
               {m0_rdata, m1_rdata, mem_address, mem_wdata});
    end
  endtask

  task automatic test_read();
    m0_address = 16'h1234; m0_read = 1'b1;
    @(negedge clk);
    n_compared++;
    if ({mem_read, mem_write, mem_address} !== {2'b10, 16'h1234}) begin
      n_mismatched++;
      $display("[TB] FAIL read_issue: got r=%b w=%b a=%h expected r=1 w=0 a=1234",
               mem_read, mem_write, mem_address);
    end
    serve(2, 8'h5A);
    n_compared++;
    if ({m0_done, m1_done, grant, mem_read} !== 4'b1000) begin
      n_mismatched++;
      $display("[TB] FAIL read_done: got d0=%b d1=%b g=%b r=%b expected 1 0 0 0",
               m0_done, m1_done, grant, mem_read);
    end
    n_compared++;
    if (m0_rdata !== 8'h5A) begin
      n_mismatched++;
      $display("[TB] FAIL read_data: got %h expected 5a", m0_rdata);
    end
    m0_read = 1'b0;
    @(negedge clk);
    n_compared++;
    if ({m0_done, m1_done, m1_rdata} !== 10'h0) begin
      n_mismatched++;
      $display("[TB] FAIL read_single_pulse: got d0=%b d1=%b m1r=%h expected 0 0 00",
               m0_done, m1_done, m1_rdata);
    end
  endtask

  task automatic test_write();
    m0_address = 16'h00FF; m0_wdata = 8'h3C; m0_write = 1'b1;
    @(negedge clk);
    n_compared++;
    if ({mem_write, mem_read, mem_address, mem_wdata} !== {2'b10, 16'h00FF, 8'h3C}) begin
      n_mismatched++;
      $display("[TB] FAIL write_issue: got w=%b r=%b a=%h d=%h expected 1 0 00ff 3c",
               mem_write, mem_read, mem_address, mem_wdata);
    end
    serve(1, 8'hA5);
    n_compared++;
    if ({m0_done, m0_rdata, mem_write} !== {1'b1, 8'h5A, 1'b0}) begin
      n_mismatched++;
      $display("[TB] FAIL write_done: got d0=%b r=%h w=%b expected 1 5a 0",
               m0_done, m0_rdata, mem_write);
    end
    m0_write = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic w;
    do_reset();
    m0_address = 16'h1000; m0_read = 1'b1;
    m1_address = 16'h2000; m1_read = 1'b1;
    @(negedge clk);
    n_compared++;
    if ({grant, mem_address} !== {1'b0, 16'h1000}) begin
      n_mismatched++;
      $display("[TB] FAIL tie_first: got g=%b a=%h expected 0 1000", grant, mem_address);
    end
    serve(1, 8'h11);
    n_compared++;
    if ({m0_done, m1_done, m0_rdata} !== {2'b10, 8'h11}) begin
      n_mismatched++;
      $display("[TB] FAIL tie_first_done: got d0=%b d1=%b r=%h expected 1 0 11",
               m0_done, m1_done, m0_rdata);
    end
    m0_read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_compared++;
    if ({grant, mem_read, mem_address} !== {2'b11, 16'h2000}) begin
      n_mismatched++;
      $display("[TB] FAIL tie_second: got g=%b r=%b a=%h expected 1 1 2000",
               grant, mem_read, mem_address);
    end
    serve(1, 8'h22);
    n_compared++;
    if ({m1_done, m0_done, m1_rdata, m0_rdata} !== {2'b10, 8'h22, 8'h11}) begin
      n_mismatched++;
      $display("[TB] FAIL tie_second_done: got d1=%b d0=%b r1=%h r0=%h expected 1 0 22 11",
               m1_done, m0_done, m1_rdata, m0_rdata);
    end
    m1_read = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      w = i[0];
      m0_address = 16'h3000 + 16'(i); m0_read = 1'b1;
      m1_address = 16'h4000 + 16'(i); m1_read = 1'b1;
      @(negedge clk);
      n_compared++;
      if ({grant, mem_address} !== {w, (w ? 16'h4000 : 16'h3000) + 16'(i)}) begin
        n_mismatched++;
        $display("[TB] FAIL alternate_%0d: got g=%b a=%h expected g=%b", i, grant,
                 mem_address, w);
      end
      serve(1, 8'h60 + 8'(i));
      n_compared++;
      if ({m1_done, m0_done} !== (w ? 2'b10 : 2'b01)) begin
        n_mismatched++;
        $display("[TB] FAIL alternate_done_%0d: got d1d0=%b expected winner %b", i,
                 {m1_done, m0_done}, w);
      end
      m0_read = 1'b0; m1_read = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    int hi;
    hi = 0;
    m0_address = 16'h5555; m0_read = 1'b1;
    @(negedge clk);
    repeat (4) begin
      if (mem_read === 1'b1) hi++;
      @(negedge clk);
    end
    n_compared++;
    if (hi !== 4) begin
      n_mismatched++;
      $display("[TB] FAIL timeout_strobe_len: got %0d expected 4", hi);
    end
    n_compared++;
    if ({mem_read, m0_done, timeout_pulse, m0_rdata} !== {3'b011, 8'hFF}) begin
      n_mismatched++;
      $display("[TB] FAIL timeout_fire: got r=%b d0=%b to=%b r0=%h expected 0 1 1 ff",
               mem_read, m0_done, timeout_pulse, m0_rdata);
    end
    m0_read = 1'b0;
    @(negedge clk);
    n_compared++;
    if ({m0_done, timeout_pulse} !== 2'b00) begin
      n_mismatched++;
      $display("[TB] FAIL timeout_pulse_len: got d0=%b to=%b expected 0 0",
               m0_done, timeout_pulse);
    end
    m1_address = 16'h6666; m1_read = 1'b1;
    @(negedge clk);
    n_compared++;
    if ({grant, mem_read, mem_address} !== {2'b11, 16'h6666}) begin
      n_mismatched++;
      $display("[TB] FAIL after_timeout_issue: got g=%b r=%b a=%h expected 1 1 6666",
               grant, mem_read, mem_address);
    end
    serve(2, 8'h77);
    n_compared++;
    if ({m1_done, timeout_pulse, m1_rdata} !== {2'b10, 8'h77}) begin
      n_mismatched++;
      $display("[TB] FAIL after_timeout_done: got d1=%b to=%b r1=%h expected 1 0 77",
               m1_done, timeout_pulse, m1_rdata);
    end
    m1_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_priority();
    m1_address = 16'hBEEF; m1_wdata = 8'hC3; m1_read = 1'b1; m1_write = 1'b1;
    @(negedge clk);
    n_compared++;
    if ({mem_write, mem_read, mem_address, mem_wdata} !== {2'b10, 16'hBEEF, 8'hC3}) begin
      n_mismatched++;
      $display("[TB] FAIL rw_issue: got w=%b r=%b a=%h d=%h expected 1 0 beef c3",
               mem_write, mem_read, mem_address, mem_wdata);
    end
    serve(1, 8'h99);
    n_compared++;
    if ({m1_done, m0_done, m1_rdata} !== {2'b10, 8'h77}) begin
      n_mismatched++;
      $display("[TB] FAIL rw_done: got d1=%b d0=%b r1=%h expected 1 0 77",
               m1_done, m0_done, m1_rdata);
    end
    m1_read = 1'b0; m1_write = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    m0_address = 16'h0ABC; m0_read = 1'b1;
    @(negedge clk);
    n_compared++;
    if (mem_read !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_access: got r=%b expected 1", mem_read);
    end
    rst_n = 1'b0;
    mem_done = 1'b1;
    mem_rdata = 8'hEE;
    @(negedge clk);
    n_compared++;
    if ({mem_read, mem_write, m0_done, m1_done, timeout_pulse, grant} !== 6'b000001) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_outputs: got %b expected 000001",
               {mem_read, mem_write, m0_done, m1_done, timeout_pulse, grant});
    end
    n_compared++;
    if ({m0_rdata, m1_rdata, mem_address} !== 32'h0) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_data: got %h expected 0",
               {m0_rdata, m1_rdata, mem_address});
    end
    rst_n = 1'b1;
    m0_read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_compared++;
    if ({m0_done, m1_done, mem_read, m0_rdata} !== 11'h0) begin
      n_mismatched++;
      $display("[TB] FAIL stray_mem_done: got d0=%b d1=%b r=%b r0=%h expected 0 0 0 00",
               m0_done, m1_done, mem_read, m0_rdata);
    end
    mem_done = 1'b0;
  endtask

  // Runs every scenario in order, then prints the summary.
  initial begin
    rst_n = 1'b0;
    test_reset();
    test_read();
    test_write();
    test_round_robin();
    test_timeout();
    test_write_priority();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
